jtag_l2_burst_bridge: RTL
=========================

# jtag_l2_burst_bridge

Burst-to-word bridge between the JTAG debug unit's memory-access engine and the L2 TCDM port inside jtagL2test. It accepts one burst command (address and word count) plus a write-data or read-data stream. It issues one single-word TCDM transaction per beat, incrementing the address by 4. Read responses are buffered in a small FIFO so a stalled JTAG shift never loses an L2 response.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; fixed at 32
- LEN_WIDTH, 8, burst length field width; burst = cmd_len_i+1 words (1..256)
- RD_FIFO_DEPTH, 2, read-response buffer entries

Ports (one clock; reset is asynchronous, active-low):
- clk_i  in  1  bridge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write burst, 0=read burst
- cmd_addr_i  in  ADDR_WIDTH  start byte address
- cmd_len_i  in  LEN_WIDTH  words minus one
- wdata_valid_i  in  1  write beat valid
- wdata_ready_o  out  1  write beat taken when valid&ready
- wdata_i  in  DATA_WIDTH  write beat
- rdata_valid_o  out  1  read beat valid (FIFO head)
- rdata_ready_i  in  1  read beat consumed
- rdata_o  out  DATA_WIDTH  read beat
- tcdm_req_o  out  1  TCDM request
- tcdm_gnt_i  in  1  TCDM grant
- tcdm_add_o  out  ADDR_WIDTH  TCDM address
- tcdm_wen_o  out  1  0=write, 1=read
- tcdm_wdata_o  out  DATA_WIDTH  TCDM write data
- tcdm_be_o  out  4  byte enables, constant 4'hF
- tcdm_r_valid_i  in  1  read response valid
- tcdm_r_rdata_i  in  DATA_WIDTH  read response data
- busy_o  out  1  state!=IDLE or FIFO non-empty
- err_o  out  1  one-cycle pulse on rejected command

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready_o=1. On accept, latch addr, len, we and clear beat counter.
    - addr[1:0]!=0: command rejected, err_o pulses next cycle, stays IDLE, no bus traffic, no write data consumed.
    - Otherwise goes to WR_DATA if we, else RD_REQ.
  - WR_DATA: wdata_ready_o=1. On beat, capture into wdata register, go to WR_REQ.
  - WR_REQ: req=1, wen=0. On gnt, if counter==len go to IDLE; else addr+=4, counter+=1, go to WR_DATA. tcdm_r_valid_i is ignored for writes.
  - RD_REQ: req=1, wen=1 only while the FIFO has at least one free slot. On gnt, go to RD_RESP.
  - RD_RESP: on r_valid, push r_rdata into the FIFO. If counter==len go to IDLE; else addr+=4, counter+=1, go to RD_REQ.
- At most one outstanding TCDM read. The credit check guarantees a push never hits a full FIFO.
- The FIFO drains independently of the FSM. A new command may be accepted while read beats are still queued.
- Address increment is modulo 2^ADDR_WIDTH: 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- Counter width is LEN_WIDTH; len=255 gives exactly 256 beats.

## Timing
- Reset values: state IDLE, so cmd_ready_o=1 during and after reset. tcdm_req_o=0, wdata_ready_o=0, rdata_valid_o=0, err_o=0, busy_o=0, FIFO empty, tcdm_add_o=0, tcdm_wdata_o=0.
- While tcdm_req_o=1, tcdm_add_o, tcdm_wen_o and tcdm_wdata_o are held stable until gnt. req is never withdrawn before gnt.
- Write throughput is 1 word per 2 cycles minimum, with zero-wait gnt and continuous wdata.
- Read latency: gnt in cycle N, r_valid in N+1 (L2 convention), rdata_valid_o in N+2 (registered FIFO output).
- A FIFO push and pop in the same cycle leaves the count unchanged. A push into an empty FIFO with rdata_ready_i=1 still appears one cycle later.
- err_o is registered: high exactly one cycle, in the cycle after the rejected handshake.
- Asserting rst_n low mid-burst aborts immediately. Nothing is replayed, and a pending TCDM grant is dropped by the reset.

## Structure
- Package jtag_l2_bridge_pkg holds:
  - state enum (IDLE, WR_DATA, WR_REQ, RD_REQ, RD_RESP)
  - BEAT_BYTES=4
  - TCDM_BE_FULL=4'hF
  - TCDM_WEN_WRITE=1'b0 and TCDM_WEN_READ=1'b1
- Sub-module jtag_l2_rd_fifo: parameterised synchronous FIFO (DEPTH, WIDTH) with push/pop/full/empty/count outputs and asynchronous active-low reset. It is instantiated once for read responses; its count feeds the read credit check.

## Test plan
- Write 1 word 0xABBAABBA to 0x0000_0000 with zero-wait gnt: exactly one req at add=0, wen=0, wdata=0xABBAABBA, be=F. Then idle, busy_o drops.
- Write burst len=3 at 0x100, then read burst len=3 at 0x100 from an L2 model: read beats return the written values in order at addresses 0x100, 0x104, 0x108, 0x10C.
- Read burst len=255 with rdata_ready_i low for 20 cycles: req is stalled after 2 responses, and no data is lost or duplicated. All 256 beats arrive after ready is restored.
- Random gnt delays (0–5 cycles): address and wdata stay stable while req=1, and every beat is issued exactly once.
- Command at 0x0000_0003: err_o high for one cycle, no tcdm_req_o, wdata_ready_o stays 0. Command at 0xFFFF_FFFC with len=1 issues addresses 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst_n low in WR_REQ mid-burst: all outputs return to reset values asynchronously, and a fresh 1-word read afterwards completes correctly.

Source files
------------

// File: rtl/jtag_l2_bridge_pkg.sv
// Shared types and constants for the JTAG-to-L2 burst bridge.
//   state_e        : bridge FSM states
//   BEAT_BYTES     : byte increment between consecutive TCDM beats
//   TCDM_BE_FULL   : byte-enable for a full 32-bit word
//   TCDM_WEN_*     : TCDM write-enable encoding (active-low write)
package jtag_l2_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_REQ  = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  localparam int unsigned BEAT_BYTES     = 4;
  localparam logic [3:0]  TCDM_BE_FULL   = 4'hF;
  localparam logic        TCDM_WEN_WRITE = 1'b0;
  localparam logic        TCDM_WEN_READ  = 1'b1;

endpackage

// File: rtl/jtag_l2_rd_fifo.sv
// Small synchronous FIFO buffering L2 read responses.
//   i_clk, rst_n : clock, asynchronous active-low reset
//   i_push/i_wdata : write side (ignored when full)
//   i_pop/o_rdata  : read side, o_rdata is the registered head entry
//   o_full, o_empty, o_count : occupancy status
module jtag_l2_rd_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers and occupancy.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/jtag_l2_burst_bridge.sv
// Burst-to-word bridge from the JTAG memory-access engine to the L2 TCDM port.
// One burst command (addr, len) becomes len+1 single-word TCDM transactions
// at addr, addr+4, ... ; read responses are buffered in a small FIFO.
//   clk_i, rst_n            : clock, asynchronous active-low reset
//   cmd_*                   : burst command handshake (we, addr, len)
//   wdata_*                 : write beat stream in
//   rdata_*                 : read beat stream out (FIFO head)
//   tcdm_*                  : single-word TCDM master port
//   busy_o, err_o           : activity flag, rejected-command pulse
module jtag_l2_burst_bridge
  import jtag_l2_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned RD_FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [DATA_WIDTH-1:0] tcdm_wdata_o,
  output logic [3:0]            tcdm_be_o,
  input  logic                  tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0] tcdm_r_rdata_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;

  logic                  w_cmd_hs;
  logic                  w_misaligned;
  logic                  w_last;
  logic                  w_credit;
  logic                  w_rd_beat;
  logic                  w_step;
  logic                  w_push;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;

  assign w_cmd_hs     = cmd_valid_i & cmd_ready_o;
  assign w_misaligned = |cmd_addr_i[1:0];
  assign w_last       = (r_cnt == r_len);
  // A read is only issued when its response is guaranteed a FIFO slot.
  assign w_credit     = (w_fifo_count < CNT_W'(RD_FIFO_DEPTH));
  assign w_rd_beat    = (r_state == RD_RESP) & tcdm_r_valid_i;
  assign w_step       = (((r_state == WR_REQ) & tcdm_gnt_i) | w_rd_beat) & ~w_last;
  assign w_push       = w_rd_beat & ~w_fifo_full;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid_i && !w_misaligned) w_state_nxt = cmd_we_i ? WR_DATA : RD_REQ;
      WR_DATA: if (wdata_valid_i) w_state_nxt = WR_REQ;
      WR_REQ:  if (tcdm_gnt_i) w_state_nxt = w_last ? IDLE : WR_DATA;
      RD_REQ:  if (tcdm_gnt_i && w_credit) w_state_nxt = RD_RESP;
      RD_RESP: if (tcdm_r_valid_i) w_state_nxt = w_last ? IDLE : RD_REQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    tcdm_req_o    = 1'b0;
    tcdm_wen_o    = TCDM_WEN_READ;
    case (r_state)
      IDLE:    cmd_ready_o   = 1'b1;
      WR_DATA: wdata_ready_o = 1'b1;
      WR_REQ: begin
        tcdm_req_o = 1'b1;
        tcdm_wen_o = TCDM_WEN_WRITE;
      end
      RD_REQ:  tcdm_req_o = w_credit;
      default: ;
    endcase
  end

  // Burst address/counter, write-data holding register and error pulse.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_cmd_hs & w_misaligned;
      if (w_cmd_hs) begin
        r_addr <= cmd_addr_i;
        r_len  <= cmd_len_i;
        r_cnt  <= '0;
      end
      if ((r_state == WR_DATA) && wdata_valid_i) r_wdata <= wdata_i;
      if (w_step) begin
        r_addr <= r_addr + ADDR_WIDTH'(BEAT_BYTES);
        r_cnt  <= r_cnt + LEN_WIDTH'(1);
      end
    end
  end

  jtag_l2_rd_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rd_fifo (
    .i_clk   (clk_i),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (tcdm_r_rdata_i),
    .i_pop   (rdata_ready_i),
    .o_rdata (rdata_o),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign tcdm_add_o    = r_addr;
  assign tcdm_wdata_o  = r_wdata;
  assign tcdm_be_o     = TCDM_BE_FULL;
  assign err_o         = r_err;
  assign rdata_valid_o = ~w_fifo_empty;
  assign busy_o        = (r_state != IDLE) | ~w_fifo_empty;

endmodule
